// File: rtl/bmd_mc_defs.sv
// Shared definitions for the SMC master-side schedulers.
// Holds the default bus widths, the address / burst-length types, the
// scheduler state encoding and a constant-foldable clog2 helper that is used
// in parameter and port-width expressions.
package bmd_mc_defs;

  localparam int unsigned SMC_ADDR_W    = 32;
  localparam int unsigned SMC_LEN_W     = 16;
  localparam int unsigned SMC_BURST_MAX = 16;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned      res;
    longint unsigned  pow;
    res = 0;
    pow = 64'd1;
    while (pow < longint'(value)) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

  typedef logic [SMC_ADDR_W-1:0]                 smc_addr_t;
  typedef logic [clog2(SMC_BURST_MAX)-1:0]       smc_trn_max_len_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/smc_burst_calc.sv
// Combinational burst sizing for SMC read/write schedulers.
// A burst never crosses a BURST_MAX-aligned boundary and never exceeds the
// words still to be transferred.
// Ports:
//   addr_lo_i  low clog2(BURST_MAX) bits of the current word address
//   rem_i      words still to be transferred
//   beats_o    beats in the next burst (0 when rem_i is 0)
//   s_len_o    beats_o - 1, the SMC burst length encoding
module smc_burst_calc
  import bmd_mc_defs::*;
#(
  parameter  int unsigned LEN_W     = 16,
  parameter  int unsigned BURST_MAX = 16,
  localparam int unsigned BW        = clog2(BURST_MAX)
) (
  input  logic [BW-1:0]    addr_lo_i,
  input  logic [LEN_W-1:0] rem_i,
  output logic [BW:0]      beats_o,
  output logic [BW-1:0]    s_len_o
);

  logic [BW:0]      room_s;
  logic [LEN_W-1:0] room_ext_s;

  // Beats left before the next aligned boundary, clipped to the remaining count.
  always_comb begin
    room_s     = (BW+1)'(BURST_MAX) - {1'b0, addr_lo_i};
    room_ext_s = LEN_W'(room_s);
    if (rem_i < room_ext_s) begin
      beats_o = rem_i[BW:0];
    end else begin
      beats_o = room_s;
    end
    // A full BURST_MAX burst has zero low bits, so the subtraction wraps to all ones.
    s_len_o = beats_o[BW-1:0] - BW'(1);
  end

endmodule

// File: rtl/smc_rd_burst_sched.sv
// Read-request scheduler in front of one SMC read master port.
// Takes one long read command (start word address, word count), splits it
// into BURST_MAX-aligned bursts, keeps at most MAX_OUTST bursts in flight and
// watches the returning data handshake for last beats to know when the whole
// command has completed.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_addr/req_len/req_valid     command in; req_ready high while idle
//   s_addr/s_len/s_avalid/s_aready burst address channel (s_len = beats-1)
//   d_valid/d_ready/d_last         observed data channel (monitor only)
//   busy                           command in progress
//   done                           one-cycle completion pulse
//   err                            sticky: last beat seen with nothing in flight
//   outst                          bursts issued but not yet terminated
// All outputs decode from registers only.
module smc_rd_burst_sched
  import bmd_mc_defs::*;
#(
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned LEN_W     = 16,
  parameter  int unsigned BURST_MAX = 16,
  parameter  int unsigned MAX_OUTST = 4,
  localparam int unsigned BW        = clog2(BURST_MAX),
  localparam int unsigned OW        = clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [BW-1:0]     s_len,
  output logic              s_avalid,
  input  logic              s_aready,
  input  logic              d_valid,
  input  logic              d_ready,
  input  logic              d_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OW-1:0]     outst
);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [BW:0]       beats_s;
  logic [BW-1:0]     blen_s;
  logic              avalid_s;
  logic              accept_s;
  logic              term_s;
  logic              term_ok_s;

  smc_burst_calc #(
    .LEN_W     (LEN_W),
    .BURST_MAX (BURST_MAX)
  ) u_calc (
    .addr_lo_i (addr_q[BW-1:0]),
    .rem_i     (rem_q),
    .beats_o   (beats_s),
    .s_len_o   (blen_s)
  );

  // Next-state, outstanding-burst accounting and error flag.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = err_q;

    avalid_s  = (state_q == SCHED_ISSUE) && (outst_q < OW'(MAX_OUTST));
    accept_s  = avalid_s && s_aready;
    term_s    = d_valid && d_ready && d_last;
    // A stray last with nothing in flight is flagged, not counted.
    term_ok_s = term_s && (outst_q != {OW{1'b0}});

    if (accept_s && !term_ok_s) begin
      outst_d = outst_q + OW'(1);
    end else if (term_ok_s && !accept_s) begin
      outst_d = outst_q - OW'(1);
    end else begin
      outst_d = outst_q;
    end

    case (state_q)
      SCHED_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          rem_d  = req_len;
          err_d  = 1'b0;
          if (req_len == {LEN_W{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d = SCHED_ISSUE;
          end
        end else begin
          state_d = SCHED_IDLE;
        end
      end
      SCHED_ISSUE: begin
        if (accept_s) begin
          addr_d = addr_q + ADDR_W'(beats_s);
          rem_d  = rem_q - LEN_W'(beats_s);
          if (rem_q == LEN_W'(beats_s)) begin
            state_d = SCHED_DRAIN;
          end else begin
            state_d = SCHED_ISSUE;
          end
        end else begin
          state_d = SCHED_ISSUE;
        end
      end
      SCHED_DRAIN: begin
        // Finish in the same cycle the final last beat lands.
        if (outst_d == {OW{1'b0}}) begin
          state_d = SCHED_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SCHED_DRAIN;
        end
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase

    // Error set wins over the clear from a command accepted in the same cycle.
    if (term_s && !term_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCHED_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      rem_q   <= {LEN_W{1'b0}};
      outst_q <= {OW{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == SCHED_IDLE);
  assign busy      = (state_q != SCHED_IDLE);
  assign s_avalid  = avalid_s;
  assign s_addr    = addr_q;
  assign s_len     = blen_s;
  assign outst     = outst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_smc_rd_burst_sched.sv
// Self-checking bench for smc_rd_burst_sched: directed scenarios followed by
// randomized commands, all checked each cycle against a queue-based model.
module tb_smc_rd_burst_sched;

  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int BURST_MAX = 16;
  localparam int MAX_OUTST = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] s_addr;
  logic [3:0]        s_len;
  logic              s_avalid;
  logic              s_aready = 1'b0;
  logic              d_valid = 1'b0;
  logic              d_ready = 1'b0;
  logic              d_last = 1'b0;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        outst;

  always #5 clk = ~clk;

  smc_rd_burst_sched #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .s_addr(s_addr), .s_len(s_len), .s_avalid(s_avalid), .s_aready(s_aready),
    .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last),
    .busy(busy), .done(done), .err(err), .outst(outst)
  );

  typedef struct {
    longint unsigned addr;
    int unsigned     slen;
  } burst_t;

  int     n_cmp = 0;
  int     n_fail = 0;
  int     n_done = 0;
  int     cyc_no = 0;

  burst_t exp_q[$];
  burst_t log_q[$];
  int     ret_q[$];
  int     m_outst = 0;
  bit     m_active = 1'b0;
  bit     m_err = 1'b0;

  bit     aready_rand = 1'b0;
  bit     aready_val = 1'b0;
  bit     ret_en = 1'b0;
  bit     force_term = 1'b0;
  bit     noise = 1'b0;
  int     ret_lat = 3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  // Expected burst list from the splitting rule, plain arithmetic.
  function automatic void plan(input longint unsigned a, input int unsigned len);
    int unsigned room;
    int unsigned b;
    exp_q.delete();
    while (len > 0) begin
      room = BURST_MAX - int'(a % BURST_MAX);
      b = (len < room) ? len : room;
      exp_q.push_back('{a, b - 1});
      a = (a + b) % (64'd1 << ADDR_W);
      len = len - b;
    end
  endfunction

  // One clock: drive responders, predict, advance, compare.
  task automatic cyc();
    bit acc, term, bad, cmd, exp_av, exp_done;
    s_aready = aready_rand ? 1'($urandom_range(0, 1)) : aready_val;
    term = force_term ||
           (ret_en && ret_q.size() > 0 && ret_q[0] <= cyc_no &&
            (!noise || $urandom_range(0, 3) != 0));
    force_term = 1'b0;
    if (term) begin
      d_valid = 1'b1; d_ready = 1'b1; d_last = 1'b1;
      if (ret_q.size() > 0) void'(ret_q.pop_front());
    end else if (noise) begin
      d_valid = 1'($urandom_range(0, 1));
      d_ready = 1'($urandom_range(0, 1));
      d_last  = (d_valid && d_ready) ? 1'b0 : 1'($urandom_range(0, 1));
    end else begin
      d_valid = 1'b0; d_ready = 1'b0; d_last = 1'b0;
    end

    exp_av = m_active && exp_q.size() > 0 && m_outst < MAX_OUTST;
    check("s_avalid", s_avalid, exp_av);
    if (exp_av) begin
      check("s_addr", s_addr, exp_q[0].addr);
      check("s_len", s_len, exp_q[0].slen);
    end
    if (s_avalid && s_aready) log_q.push_back('{s_addr, s_len});

    acc = exp_av && s_aready;
    bad = term && m_outst == 0;
    cmd = !m_active && req_valid;
    exp_done = 1'b0;
    if (acc) begin
      void'(exp_q.pop_front());
      ret_q.push_back(cyc_no + ret_lat + 1);
    end
    m_outst = m_outst + int'(acc) - int'(term && !bad);
    if (cmd) begin
      m_err = 1'b0;
      plan(req_addr, req_len);
      if (req_len == 0) exp_done = 1'b1;
      else m_active = 1'b1;
    end else if (m_active && exp_q.size() == 0 && m_outst == 0) begin
      m_active = 1'b0;
      exp_done = 1'b1;
    end
    if (bad) m_err = 1'b1;

    @(posedge clk); #1;
    cyc_no++;
    if (done) n_done++;
    check("outst", outst, m_outst);
    check("done", done, exp_done);
    check("err", err, m_err);
    check("busy", busy, m_active);
    check("req_ready", req_ready, !m_active);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; s_aready = 1'b0;
    d_valid = 1'b0; d_ready = 1'b0; d_last = 1'b0;
    @(posedge clk); #1;
    cyc_no++;
    rst = 1'b0;
    m_outst = 0; m_active = 1'b0; m_err = 1'b0;
    exp_q.delete(); ret_q.delete();
    check("rst_outst", outst, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_avalid", s_avalid, 0);
    check("rst_err", err, 0);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] l);
    req_addr = a; req_len = l; req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (m_active && n < bound) begin
      cyc();
      n++;
    end
    check("idle_busy", busy, 0);
  endtask

  task automatic chk_burst(input string tag, input int idx, input logic [31:0] a, input logic [3:0] l);
    if (idx < log_q.size()) begin
      check(tag, log_q[idx].addr, a);
      check(tag, log_q[idx].slen, l);
    end else begin
      check({tag, "_count"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    int d0;
    logic [31:0] ra;
    logic [15:0] rl;

    do_reset();

    // Aligned split with a last three cycles after each burst.
    aready_val = 1'b1; ret_en = 1'b1; ret_lat = 3;
    log_q.delete(); d0 = n_done;
    send_cmd(32'h100, 16'd40);
    wait_idle(200);
    check("t1_nburst", log_q.size(), 3);
    chk_burst("t1_b0", 0, 32'h100, 4'd15);
    chk_burst("t1_b1", 1, 32'h110, 4'd15);
    chk_burst("t1_b2", 2, 32'h120, 4'd7);
    check("t1_ndone", n_done - d0, 1);
    check("t1_outst", outst, 0);

    // Unaligned start.
    log_q.delete(); d0 = n_done;
    send_cmd(32'h105, 16'd20);
    wait_idle(200);
    check("t2_nburst", log_q.size(), 2);
    chk_burst("t2_b0", 0, 32'h105, 4'd10);
    chk_burst("t2_b1", 1, 32'h110, 4'd8);
    check("t2_ndone", n_done - d0, 1);

    // Credit limit: nothing returns until four bursts are out.
    ret_en = 1'b0; log_q.delete();
    send_cmd(32'h0, 16'd128);
    repeat (8) cyc();
    check("t3_outst_max", outst, 4);
    check("t3_avalid_off", s_avalid, 0);
    check("t3_nburst", log_q.size(), 4);
    force_term = 1'b1;
    cyc();
    check("t3_avalid_on", s_avalid, 1);
    check("t3_addr5", s_addr, 32'h40);
    check("t3_len5", s_len, 15);
    ret_en = 1'b1; ret_lat = 0;
    wait_idle(400);

    // Backpressure: address channel must hold.
    aready_val = 1'b0;
    send_cmd(32'h200, 16'd64);
    repeat (5) begin
      check("t4_hold_valid", s_avalid, 1);
      check("t4_hold_addr", s_addr, 32'h200);
      check("t4_hold_len", s_len, 15);
      cyc();
    end
    aready_val = 1'b1;
    wait_idle(400);

    // Zero-length command.
    d0 = n_done; log_q.delete();
    send_cmd(32'h300, 16'd0);
    check("t4_zero_done", done, 1);
    check("t4_zero_avalid", s_avalid, 0);
    cyc();
    check("t4_zero_pulse", done, 0);
    check("t4_zero_noburst", log_q.size(), 0);

    // Accept coincident with a termination at outst=2.
    ret_en = 1'b0;
    send_cmd(32'h0, 16'd64);
    cyc(); cyc();
    check("t5_outst2", outst, 2);
    force_term = 1'b1;
    cyc();
    check("t5_outst_same", outst, 2);
    ret_en = 1'b1;
    wait_idle(400);

    // Stray last while idle raises sticky err, cleared by the next command.
    force_term = 1'b1;
    cyc();
    check("t5_err_set", err, 1);
    cyc(); cyc();
    check("t5_err_held", err, 1);
    check("t5_err_outst", outst, 0);
    send_cmd(32'h10, 16'd5);
    check("t5_err_clr", err, 0);
    wait_idle(200);

    // Reset while draining three bursts.
    ret_en = 1'b0;
    send_cmd(32'h0, 16'd48);
    repeat (4) cyc();
    check("t6_outst3", outst, 3);
    check("t6_busy", busy, 1);
    d0 = n_done;
    do_reset();
    cyc();
    check("t6_nodone", n_done - d0, 0);

    // Randomized commands with random backpressure, latency and data noise.
    noise = 1'b1; aready_rand = 1'b1; ret_en = 1'b1;
    repeat (25) begin
      ret_lat = $urandom_range(0, 6);
      ra = $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      rl = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 150));
      d0 = n_done;
      send_cmd(ra, rl);
      wait_idle(3000);
      check("rnd_one_done", n_done - d0, 1);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/smc_rd_burst_sched.md
Name: smc_rd_burst_sched

Overview:
- Read-request scheduler in front of one SMC read master port, e.g. one input of the ANB read crossbar.
- Accepts one long read command (start word address, total word count) and splits it into SMC bursts of at most BURST_MAX beats.
- Bursts are aligned to BURST_MAX boundaries, and at most MAX_OUTST bursts may be in flight at once.
- Monitors the returning data handshake to track completion, and pulses done when every issued burst has delivered its last beat.

Parameters:
- ADDR_W, 32, word-address width.
- LEN_W, 16, width of the total request word count.
- BURST_MAX, 16, maximum beats per burst; must be a power of two, ≥2.
- MAX_OUTST, 4, maximum bursts issued but not yet terminated by last; ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  total words; 0 is legal.
- req_valid  in  1  command valid.
- req_ready  out  1  scheduler idle, command accepted on valid&ready.
- s_addr  out  ADDR_W  burst start word address.
- s_len  out  clog2(BURST_MAX)  burst beats minus 1.
- s_avalid  out  1  burst address valid.
- s_aready  in  1  slave accepts burst.
- d_valid  in  1  observed data-beat valid (monitor only).
- d_ready  in  1  observed data-beat ready (monitor only).
- d_last  in  1  observed last beat of a burst.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol error.
- outst  out  clog2(MAX_OUTST+1)  current in-flight burst count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; s_avalid=0, done=0, err=0, busy=0, outst=0, req_ready=1.
  - Internal address and remaining-count registers are cleared.
  - Reset mid-operation abandons the command; in-flight bursts are forgotten; no done pulse is produced.
- Outputs: s_avalid, s_addr, s_len, busy, done, err and outst are all decoded from registers. There is no combinational path from s_aready, d_* or req_valid to any output.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr←req_addr and rem←req_len, and clear err.
  - If req_len==0: stay in IDLE, and done=1 on the next cycle.
  - Otherwise go to ISSUE with busy=1.
- ISSUE:
  - Burst beats: beats = min(rem, BURST_MAX − (addr mod BURST_MAX)). s_len=beats−1 and s_addr=addr.
  - s_avalid=1 whenever outst<MAX_OUTST.
  - Once s_avalid is asserted, s_addr and s_len are held stable until s_avalid&s_aready.
  - On acceptance: addr+=beats, rem−=beats, outst+=1. If rem becomes 0, go to DRAIN.
  - Acceptance and a new burst issue may occur on consecutive cycles.
- Termination: d_valid&d_ready&d_last decrements outst in any state.
  - Simultaneous accept and termination in the same cycle leave outst unchanged.
  - When outst==MAX_OUTST, a termination in cycle t allows s_avalid=1 in cycle t+1.
- DRAIN:
  - s_avalid=0.
  - When outst==0 (including the cycle where the final termination lands), go to IDLE and assert done for exactly one cycle. busy falls in the same cycle.
- err: set, and held until the next accepted command, if a termination arrives while outst==0. outst saturates at 0 in that case.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top is not flagged.
- rem uses LEN_W bits; beats uses clog2(BURST_MAX)+1 bits.

Decomposition:
- Package bmd_mc_defs holds the shared types and helpers: smc_addr_t, smc_trn_max_len_t, clog2, and a new sched_state_t enum.
- Sub-module smc_burst_calc (combinational) computes beats and s_len from addr, rem and BURST_MAX; it is reused by the write-side scheduler.
- The FSM, the outstanding counter and the error flag stay in the top module.

Test Plan:
- Aligned split. Command addr=0x100, len=40, s_aready=1, a last returned 3 cycles after each burst → bursts (0x100,s_len 15), (0x110,15), (0x120,7); one done pulse after the third last; outst returns to 0.
- Unaligned start. addr=0x105, len=20 → bursts (0x105,s_len 10), (0x110,8); done after 2 lasts.
- Credit limit. addr=0, len=128, no d_last → exactly 4 bursts issued, then s_avalid=0 with outst=4. One d_last → 5th burst (0x40,15) presented the next cycle.
- Backpressure and zero length. Hold s_aready=0 for 5 cycles → s_addr/s_len stable and s_avalid held. Command with len=0 → done=1 one cycle after accept and no s_avalid.
- Simultaneous events. Accept coincident with d_last at outst=2 → outst stays 2. A d_last with outst=0 → err=1, held until the next command is accepted.
- Reset mid-DRAIN. Assert rst with outst=3 → the next cycle shows outst=0, busy=0, req_ready=1, and no done pulse.
